// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: N-bit word in via load_valid/load_ready, shifted out LSB first.
// Optional PISO_PARITY_EN appends an even-parity bit after bit N-1 as the frame's last bit.
`timescale 1ns/1ps

module piso_serializer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] D,
  output logic         SO,
  output logic         so_valid,
  output logic         so_last,
  output logic         busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  state_t        r_state;
  logic [N-1:0]  r_sreg;
  logic [CW-1:0] r_cnt;
  logic          r_so;
  logic          r_so_valid;
  logic          r_so_last;
`ifdef PISO_PARITY_EN
  logic          r_par;
`endif

  logic w_accept;
  logic w_final_bit;

  // A new word may be taken in the frame's last cycle, giving gapless streaming.
  assign load_ready  = reset_n & ((r_state == IDLE) | r_so_last);
  assign w_accept    = load_valid & load_ready;
  assign w_final_bit = (r_cnt == CW'(N - 1));

  assign SO       = r_so;
  assign so_valid = r_so_valid;
  assign so_last  = r_so_last;
  assign busy     = r_so_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_sreg     <= '0;
      r_cnt      <= '0;
      r_so       <= 1'b0;
      r_so_valid <= 1'b0;
      r_so_last  <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state    <= SHIFT;
      r_sreg     <= D;
      r_cnt      <= '0;
      r_so       <= D[0];
      r_so_valid <= 1'b1;
      r_so_last  <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par      <= ^D;
`endif
    end else begin
      case (r_state)
        SHIFT: begin
          r_sreg <= r_sreg >> 1;
          r_cnt  <= r_cnt + CW'(1);
          if (w_final_bit) begin
`ifdef PISO_PARITY_EN
            r_state   <= PARITY;
            r_so      <= r_par;
            r_so_last <= 1'b1;
`else
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_so       <= 1'b0;
            r_so_valid <= 1'b0;
            r_so_last  <= 1'b0;
`endif
          end else begin
            r_so <= r_sreg[1];
`ifdef PISO_PARITY_EN
            r_so_last <= 1'b0;
`else
            r_so_last <= (r_cnt == CW'(N - 2));
`endif
          end
        end
        PARITY: begin
          r_state    <= IDLE;
          r_cnt      <= '0;
          r_so       <= 1'b0;
          r_so_valid <= 1'b0;
          r_so_last  <= 1'b0;
        end
        default: begin
          r_so       <= 1'b0;
          r_so_valid <= 1'b0;
          r_so_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: queue-based frame model checked every cycle plus directed literal checks.
`timescale 1ns/1ps

module tb_piso_serializer;

  localparam int N = 4;
`ifdef PISO_PARITY_EN
  localparam int FL  = N + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int FL  = N;
  localparam bit PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       load_valid = 1'b0;
  logic [3:0] D = 4'h0;
  logic       load_ready, SO, so_valid, so_last, busy;

  logic       lv8 = 1'b0;
  logic [7:0] d8 = 8'h00;
  logic       rdy8, so8, vld8, last8, busy8;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  piso_serializer #(.N(4)) dut (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_ready(load_ready),
    .D(D), .SO(SO), .so_valid(so_valid), .so_last(so_last), .busy(busy)
  );

  piso_serializer #(.N(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .load_valid(lv8), .load_ready(rdy8),
    .D(d8), .SO(so8), .so_valid(vld8), .so_last(last8), .busy(busy8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of pending {last, bit} symbols; head is what SO shows this cycle.
  logic [1:0] q[$];
  logic       m_rdy;

  always @(posedge clk) begin
    if (reset_n) begin
      m_rdy = (q.size() == 0) ? 1'b1 : q[0][1];
      if (q.size() > 0) void'(q.pop_front());
      if (load_valid && m_rdy) begin
        for (int i = 0; i < N; i++) q.push_back({(!PAR && i == N - 1), D[i]});
        if (PAR) q.push_back({1'b1, ^D});
      end
    end
  end

  always @(negedge reset_n) q.delete();

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [1:0] e;
      logic       ev, er;
      e  = (q.size() > 0 && reset_n) ? q[0] : 2'b00;
      ev = reset_n && (q.size() > 0);
      er = reset_n && (!ev || e[1]);
      chk("m_SO", SO, e[0]);
      chk("m_so_valid", so_valid, ev);
      chk("m_so_last", so_last, e[1]);
      chk("m_busy", busy, ev);
      chk("m_load_ready", load_ready, er);
    end
  end

  // Companion right-shift SIPO on the N=8 instance, stops after 8 data bits.
  logic [7:0] sipo = 8'h00;
  int         sbits = 0;
  always @(posedge clk) begin
    if (vld8 && sbits < 8) begin
      sipo  <= {so8, sipo[7:1]};
      sbits <= sbits + 1;
    end
  end

  task automatic frame4(input logic [3:0] d, output logic [3:0] bits, output logic [3:0] lasts,
                        output logic pbit, output logic plast, output int vcnt);
    @(negedge clk); load_valid = 1'b1; D = d;
    @(negedge clk); load_valid = 1'b0;
    vcnt = 0;
    for (int i = 0; i < N; i++) begin
      if (i > 0) @(negedge clk);
      bits[i]  = SO;
      lasts[i] = so_last;
      vcnt     += int'(so_valid);
    end
    pbit = 1'b0; plast = 1'b0;
    if (PAR) begin
      @(negedge clk);
      pbit = SO; plast = so_last; vcnt += int'(so_valid);
    end
    @(negedge clk);
    vcnt += int'(so_valid);
  endtask

  logic [3:0] bits, lasts;
  logic       pbit, plast;
  int         vcnt;
  logic [7:0] got;
  int         ones;

  initial begin
    #2 reset_n = 1'b0;
    #1;
    chk("rst_SO", SO, 0);
    chk("rst_so_valid", so_valid, 0);
    chk("rst_so_last", so_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load_ready", load_ready, 0);
    chk("rst_busy8", busy8, 0);
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("idle_load_ready", load_ready, 1);

    // Single word 1011
    frame4(4'hB, bits, lasts, pbit, plast, vcnt);
    chk("t1_bits", bits, 4'hB);
    chk("t1_lasts", lasts, PAR ? 4'h0 : 4'h8);
    chk("t1_valid_cycles", vcnt, FL);
    chk("t1_busy_after", busy, 0);
    chk("t1_ready_after", load_ready, 1);
`ifdef PISO_PARITY_EN
    chk("t1_parity_bit", pbit, 1);
    chk("t1_parity_last", plast, 1);
    frame4(4'h3, bits, lasts, pbit, plast, vcnt);
    chk("t6_parity_bit", pbit, 0);
    chk("t6_parity_last", plast, 1);
`endif

    // Back-to-back A then 5 with load_valid held
    @(negedge clk); load_valid = 1'b1; D = 4'hA;
    @(negedge clk); D = 4'h5;
    got[0] = SO; vcnt = int'(so_valid);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      got[i] = SO;
      vcnt += int'(so_valid);
      if (i == FL) load_valid = 1'b0;
    end
    chk("t2_valid_run", vcnt, 8);
`ifndef PISO_PARITY_EN
    chk("t2_stream", got, 8'h5A);
`endif
    repeat (FL) @(negedge clk);
    chk("t2_idle_after", so_valid, 0);

    // Word 0 with a load pulse mid-frame that must be ignored
    @(negedge clk); load_valid = 1'b1; D = 4'h0;
    @(negedge clk); load_valid = 1'b0;
    ones = int'(SO); vcnt = int'(so_valid);
    @(negedge clk); load_valid = 1'b1; D = 4'hF;
    ones += int'(SO); vcnt += int'(so_valid);
    @(negedge clk);
    ones += int'(SO); vcnt += int'(so_valid);
    @(negedge clk); load_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ones += int'(SO); vcnt += int'(so_valid);
      @(negedge clk);
    end
    chk("t3_ones", ones, 0);
    chk("t3_valid_cycles", vcnt, FL);

    // Async reset during bit 2 of 0110
    @(negedge clk); load_valid = 1'b1; D = 4'h6;
    @(negedge clk); load_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("t4_bit2_pre", SO, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("t4_SO_abort", SO, 0);
    chk("t4_valid_abort", so_valid, 0);
    chk("t4_busy_abort", busy, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    frame4(4'h9, bits, lasts, pbit, plast, vcnt);
    chk("t4_after_bits", bits, 4'h9);
    chk("t4_after_valid", vcnt, FL);

    // N=8 instance with companion SIPO
    @(negedge clk); lv8 = 1'b1; d8 = 8'hC3;
    @(negedge clk); lv8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      got[i] = so8;
      if (i == 7) chk("t5_last_on_bit7", last8, PAR ? 0 : 1);
    end
    chk("t5_bits", got, 8'hC3);
    @(negedge clk);
    chk("t5_sipo", sipo, 8'hC3);
    repeat (2) @(negedge clk);
    chk("t5_ready8_idle", rdy8, 1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
